// File: rtl/a2d_pkg.sv
// Shared types and constants for the ADC conversion interface.
package a2d_pkg;

    // Conversion sequencer states.
    typedef enum logic [1:0] {IDLE, FRM1, GAP, FRM2} state_t;

    // Divider preload gives SCLK high for 9 clks before the first fall.
    localparam logic [4:0]  SCLK_LOAD  = 5'b10111;
    // Divider value 2 clks after each SCLK rise; MISO is captured here.
    localparam logic [4:0]  SAMPLE_PT  = 5'b10001;
    // Divider value at which a frame with all bits sampled terminates.
    localparam logic [4:0]  FRAME_END  = 5'b11110;
    localparam logic [10:0] CMD_PAD    = 11'h000;
    localparam int unsigned FRAME_BITS = 16;

endpackage

// File: rtl/spi_mstr16.sv
// Single 16-bit SPI frame engine: SCLK = clk/32, idles high, samples MISO
// two clks after each rising edge, shifts MOSI out of the MSB.
module spi_mstr16
    import a2d_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    logic        ss_n_q, ss_n_d;
    logic [4:0]  div_q, div_d;
    logic [15:0] shft_q, shft_d;
    logic [4:0]  smp_q, smp_d;

    // Frame load, divider advance, sampling and end-of-frame detection.
    always_comb begin
        ss_n_d = ss_n_q;
        div_d  = div_q;
        shft_d = shft_q;
        smp_d  = smp_q;
        done   = 1'b0;
        if (wrt) begin
            ss_n_d = 1'b0;
            div_d  = SCLK_LOAD;
            shft_d = cmd;
            smp_d  = 5'd0;
        end else if (!ss_n_q) begin
            // Divider value 11110 also occurs before the first sample; the
            // sample count keeps that early pass from ending the frame.
            if (div_q == FRAME_END && smp_q == 5'(FRAME_BITS)) begin
                done   = 1'b1;
                ss_n_d = 1'b1;
            end else begin
                div_d = div_q + 5'd1;
                if (div_q == SAMPLE_PT) begin
                    shft_d = {shft_q[14:0], MISO};
                    smp_d  = smp_q + 5'd1;
                end
            end
        end
    end

    // Frame engine state; divider resets to a value with bit 4 set so SCLK idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_q <= 1'b1;
            div_q  <= FRAME_END;
            shft_q <= 16'h0000;
            smp_q  <= 5'd0;
        end else begin
            ss_n_q <= ss_n_d;
            div_q  <= div_d;
            shft_q <= shft_d;
            smp_q  <= smp_d;
        end
    end

    assign SS_n    = ss_n_q;
    assign SCLK    = div_q[4] | ss_n_q;
    assign MOSI    = shft_q[15];
    assign rd_data = shft_q;

endmodule

// File: rtl/a2d_intf.sv
// ADC conversion sequencer: channel command frame, chip-select gap, result
// frame, then a sticky completion flag with the 12-bit result.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int unsigned GAP_CLKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int unsigned GapW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    state_t          state_q, state_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [11:0]     res_q, res_d;
    logic            cmplt_q, cmplt_d;
    logic            wrt;
    logic [15:0]     cmd;
    logic [15:0]     rd_data;
    logic            done;
    logic            unused_rd_hi;

    spi_mstr16 u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .rd_data (rd_data),
        .done    (done),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    // Only the low 12 bits of the second frame carry the conversion.
    assign unused_rd_hi = ^rd_data[15:12];

    // Next-state sequencing of the two frames and the chip-select gap.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        res_d   = res_q;
        cmplt_d = cmplt_q;
        wrt     = 1'b0;
        cmd     = 16'h0000;
        unique case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    wrt     = 1'b1;
                    cmd     = {2'b00, chnnl, CMD_PAD};
                    cmplt_d = 1'b0;
                    state_d = FRM1;
                end
            end
            FRM1: begin
                if (done) begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + GapW'(1);
                if (gap_q == GapW'(GAP_CLKS - 1)) begin
                    wrt     = 1'b1;
                    state_d = FRM2;
                end
            end
            FRM2: begin
                if (done) begin
                    res_d   = rd_data[11:0];
                    cmplt_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, result and completion registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
            res_q   <= 12'h000;
            cmplt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            res_q   <= res_d;
            cmplt_q <= cmplt_d;
        end
    end

    assign res       = res_q;
    assign cnv_cmplt = cmplt_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Self-checking bench for a2d_intf with a behavioural SPI ADC model and bus monitor.
module tb_a2d_intf;

    localparam int GAP        = 32;
    localparam int FRAME_CLKS = 520;
    localparam int LATENCY    = 2 * FRAME_CLKS + GAP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO = 1'b0;

    int checks = 0;
    int errors = 0;

    a2d_intf #(.GAP_CLKS(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ADC model and bus monitor ----------------
    typedef struct {
        logic [15:0] mosi;
        int          rises;
        int          low_len;
        int          first_fall;
    } frame_t;

    frame_t      frames[$];
    int          gaps[$];
    int          lats[$];
    logic [11:0] adc_data = 12'h000;
    int          sclk_viol = 0;
    int          idle_viol = 0;

    bit          ss_prev = 1'b1, sclk_prev = 1'b1, cmplt_prev = 1'b0;
    bit          in_frame = 1'b0, have_rise = 1'b0, par = 1'b0;
    int          ss_fall_cyc, ss_rise_cyc, conv_cyc, last_rise, last_fall, n_falls, bitidx;
    frame_t      cur;
    logic [15:0] miso_word;

    // The ADC drives a new bit on each SCLK fall; the monitor logs MOSI on each rise.
    always @(negedge clk) begin
        if (!rst_n) begin
            ss_prev = 1'b1; sclk_prev = 1'b1; cmplt_prev = 1'b0;
            in_frame = 1'b0; have_rise = 1'b0; par = 1'b0; MISO = 1'b0;
        end else begin
            if (SS_n && !SCLK) idle_viol++;
            if (ss_prev && !SS_n) begin
                if (have_rise && par) gaps.push_back(cyc - ss_rise_cyc);
                in_frame = 1'b1; ss_fall_cyc = cyc; n_falls = 0; bitidx = 15;
                cur.mosi = 16'h0; cur.rises = 0; cur.first_fall = -1; cur.low_len = 0;
                if (!par) begin
                    conv_cyc  = cyc;
                    miso_word = 16'($urandom);
                end else begin
                    miso_word = {4'($urandom), adc_data};
                end
                par = !par;
            end
            if (in_frame && !SS_n) begin
                if (sclk_prev && !SCLK) begin
                    if (n_falls == 0) cur.first_fall = cyc - ss_fall_cyc;
                    else if (cyc - last_rise != 16) sclk_viol++;
                    n_falls++;
                    last_fall = cyc;
                    MISO = miso_word[bitidx];
                    if (bitidx > 0) bitidx--;
                end
                if (!sclk_prev && SCLK) begin
                    if (cyc - last_fall != 16) sclk_viol++;
                    cur.rises++;
                    last_rise = cyc;
                    cur.mosi = {cur.mosi[14:0], MOSI};
                end
            end
            if (in_frame && !ss_prev && SS_n) begin
                cur.low_len = cyc - ss_fall_cyc;
                frames.push_back(cur);
                in_frame = 1'b0; have_rise = 1'b1; ss_rise_cyc = cyc;
            end
            if (!cmplt_prev && cnv_cmplt) lats.push_back(cyc - conv_cyc);
            ss_prev = SS_n; sclk_prev = SCLK; cmplt_prev = cnv_cmplt;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_conv(input logic [2:0] c);
        strt_cnv = 1'b1;
        chnnl    = c;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
        chnnl    = 3'($urandom);
        frames.delete(); gaps.delete(); lats.delete();
    endtask

    task automatic wait_cmplt();
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1) seen = 1'b1;
        end
        #1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL cmplt_timeout: got no cnv_cmplt, required cnv_cmplt=1 within 3000 clks");
        end
    endtask

    function automatic logic [15:0] frame_mosi(input int idx);
        return (frames.size() > idx) ? frames[idx].mosi : 16'hxxxx;
    endfunction

    function automatic int first_lat();
        return (lats.size() > 0) ? lats[0] : -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL rst_ss_n: got %b required 1", SS_n); end
        checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL rst_sclk: got %b required 1", SCLK); end
        checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b required 0", MOSI); end
        checks++; if (cnv_cmplt !== 1'b0) begin errors++; $display("FAIL rst_cmplt: got %b required 0", cnv_cmplt); end
        checks++; if (res !== 12'h000) begin errors++; $display("FAIL rst_res: got %h required 000", res); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL idle_ss_n: got %b required 1", SS_n); end
    endtask

    task automatic test_basic();
        adc_data = 12'hA5C;
        start_conv(3'b101);
        wait_cmplt();
        checks++; if (res !== 12'hA5C) begin errors++; $display("FAIL basic_res: got %h required a5c", res); end
        checks++; if (frame_mosi(0) !== 16'h2800) begin errors++; $display("FAIL basic_cmd: got %h required 2800", frame_mosi(0)); end
        checks++; if (frame_mosi(1) !== 16'h0000) begin errors++; $display("FAIL basic_frm2: got %h required 0000", frame_mosi(1)); end
        checks++; if (first_lat() != LATENCY) begin errors++; $display("FAIL basic_latency: got %0d required %0d", first_lat(), LATENCY); end
    endtask

    task automatic test_sclk_timing();
        logic [2:0] c = 3'($urandom);
        adc_data = 12'($urandom);
        sclk_viol = 0; idle_viol = 0;
        start_conv(c);
        wait_cmplt();
        checks++; if (frames.size() != 2) begin errors++; $display("FAIL tim_frames: got %0d required 2", frames.size()); end
        foreach (frames[i]) begin
            checks++; if (frames[i].rises != 16) begin errors++; $display("FAIL tim_rises%0d: got %0d required 16", i, frames[i].rises); end
            checks++; if (frames[i].low_len != FRAME_CLKS) begin errors++; $display("FAIL tim_ss_low%0d: got %0d required %0d", i, frames[i].low_len, FRAME_CLKS); end
            checks++; if (frames[i].first_fall != 9) begin errors++; $display("FAIL tim_first_fall%0d: got %0d required 9", i, frames[i].first_fall); end
        end
        checks++; if (gaps.size() != 1 || gaps[0] != GAP) begin errors++; $display("FAIL tim_gap: got %0d entries (first %0d) required 1 of %0d", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1, GAP); end
        checks++; if (sclk_viol != 0) begin errors++; $display("FAIL tim_half_period: got %0d violations required 0", sclk_viol); end
        checks++; if (idle_viol != 0) begin errors++; $display("FAIL tim_idle_sclk: got %0d violations required 0", idle_viol); end
        checks++; if (res !== adc_data) begin errors++; $display("FAIL tim_res: got %h required %h", res, adc_data); end
    endtask

    task automatic test_busy();
        adc_data = 12'($urandom);
        start_conv(3'b001);
        repeat (200) @(posedge clk);
        #1;
        strt_cnv = 1'b1; chnnl = 3'b010;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chnnl = 3'b110;
        wait_cmplt();
        checks++; if (frame_mosi(0) !== 16'h0800) begin errors++; $display("FAIL busy_cmd: got %h required 0800", frame_mosi(0)); end
        checks++; if (first_lat() != LATENCY) begin errors++; $display("FAIL busy_latency: got %0d required %0d", first_lat(), LATENCY); end
        checks++; if (res !== adc_data) begin errors++; $display("FAIL busy_res: got %h required %h", res, adc_data); end
        repeat (1200) @(negedge clk);
        checks++; if (frames.size() != 2) begin errors++; $display("FAIL busy_no_restart: got %0d frames required 2", frames.size()); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] first = 12'($urandom) | 12'h001;
        logic [11:0] second = 12'($urandom);
        adc_data = first;
        start_conv(3'b011);
        wait_cmplt();
        adc_data = second;
        start_conv(3'b111);
        checks++; if (cnv_cmplt !== 1'b0) begin errors++; $display("FAIL b2b_cmplt_drop: got %b required 0", cnv_cmplt); end
        checks++; if (SS_n !== 1'b0) begin errors++; $display("FAIL b2b_ss_fall: got %b required 0", SS_n); end
        repeat (700) @(posedge clk);
        #1;
        checks++; if (res !== first) begin errors++; $display("FAIL b2b_res_held: got %h required %h", res, first); end
        wait_cmplt();
        checks++; if (frame_mosi(0) !== 16'h3800) begin errors++; $display("FAIL b2b_cmd: got %h required 3800", frame_mosi(0)); end
        checks++; if (res !== second) begin errors++; $display("FAIL b2b_res: got %h required %h", res, second); end
        checks++; if (first_lat() != LATENCY) begin errors++; $display("FAIL b2b_latency: got %0d required %0d", first_lat(), LATENCY); end
    endtask

    task automatic test_reset_mid();
        adc_data = 12'h5A5;
        start_conv(3'b100);
        repeat (800) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL midrst_ss_n: got %b required 1", SS_n); end
        checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL midrst_sclk: got %b required 1", SCLK); end
        checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL midrst_mosi: got %b required 0", MOSI); end
        checks++; if (cnv_cmplt !== 1'b0) begin errors++; $display("FAIL midrst_cmplt: got %b required 0", cnv_cmplt); end
        checks++; if (res !== 12'h000) begin errors++; $display("FAIL midrst_res: got %h required 000", res); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        adc_data = 12'hFFF;
        start_conv(3'b000);
        wait_cmplt();
        checks++; if (res !== 12'hFFF) begin errors++; $display("FAIL midrst_res_after: got %h required fff", res); end
        checks++; if (frame_mosi(0) !== 16'h0000) begin errors++; $display("FAIL midrst_cmd: got %h required 0000", frame_mosi(0)); end
    endtask

    task automatic test_channel_sweep();
        logic [11:0] pat [8];
        logic [15:0] want;
        logic [15:0] got;
        pat[0] = 12'h000; pat[1] = 12'h001; pat[2] = 12'h800; pat[3] = 12'hFFF;
        for (int i = 4; i < 8; i++) pat[i] = 12'($urandom);
        for (int c = 0; c < 8; c++) begin
            adc_data = pat[c];
            start_conv(3'(c));
            wait_cmplt();
            want = 16'(c) << 11;
            got  = frame_mosi(0);
            checks++; if (got[13:11] !== 3'(c)) begin errors++; $display("FAIL sweep_chnnl%0d: got %0d required %0d", c, got[13:11], c); end
            checks++; if (got !== want) begin errors++; $display("FAIL sweep_cmd%0d: got %h required %h", c, got, want); end
            checks++; if (res !== pat[c]) begin errors++; $display("FAIL sweep_res%0d: got %h required %h", c, res, pat[c]); end
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sclk_timing();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_channel_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2d_intf.md
Name: a2d_intf

Overview:
- SPI master that services the conversion requests issued by the motion controller.
- Accepts strt_cnv/chnnl, runs two 16-bit SPI frames to the external 8-channel 12-bit ADC, and returns res with a sticky cnv_cmplt.
- Frame 1 sends the channel command. Frame 2 clocks out the conversion result.
- Sits between motion_cntrl and the board ADC pins.

Parameters:
GAP_CLKS, 32, clk cycles SS_n is held high between frame 1 and frame 2 (min 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
strt_cnv  input  1  single-cycle request to start a conversion
chnnl  input  3  ADC channel, latched when strt_cnv is accepted
cnv_cmplt  output  1  high when res is valid; sticky until next accepted strt_cnv
res  output  12  last conversion result
SS_n  output  1  ADC chip select, active low
SCLK  output  1  SPI clock, clk/32, idles high
MOSI  output  1  SPI data to ADC
MISO  input  1  SPI data from ADC

Behaviour:
- Reset (rst_n is asynchronous, active-low; clock is clk):
  - SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=0, FSM in IDLE.
  - Reset asserted mid-frame aborts immediately to these values; no partial res update.
- Accept rule:
  - strt_cnv is accepted only in IDLE.
  - On acceptance: chnnl is latched, cnv_cmplt clears on the same edge, and SS_n falls on that same edge (cycle 0).
  - strt_cnv while busy is ignored. chnnl changes while busy are ignored.
- FSM states and transitions:
  - IDLE: on strt_cnv, go to FRM1.
  - FRM1: on frame done, go to GAP.
  - GAP: after GAP_CLKS cycles, go to FRM2.
  - FRM2: on frame done, go to IDLE.
- Frame engine:
  - Uses a 5-bit divider sclk_div; SCLK = sclk_div[4].
  - At frame start, sclk_div is loaded with 5'b10111 and a 16-bit shift register with the frame word.
  - sclk_div increments every clk while the frame is active.
  - Falling SCLK edge occurs at 11111->00000; rising SCLK edge occurs at 01111->10000.
  - Sample event is the cycle sclk_div==5'b10001, i.e. 2 clks after each rise.
  - On each sample event: shft <= {shft[14:0], MISO}.
  - MOSI = shft[15], so MOSI changes mid-high phase and is stable at the next rise.
- Frame timing:
  - First fall is at cycle 9, first rise at cycle 25.
  - Exactly 16 rises per frame; sample 16 is at cycle 507.
  - Frame ends when, after sample 16, sclk_div reaches 5'b11110 (cycle 520). SS_n rises on that edge and the divider freezes.
  - SCLK is high whenever SS_n is high.
- Frame words:
  - FRM1 sends {2'b00, chnnl_latched, 11'h000}. MISO data captured in FRM1 is discarded.
  - FRM2 sends 16'h0000.
- Completion:
  - At the edge ending FRM2, res <= shft[11:0] (post-shift value including sample 16) and cnv_cmplt <= 1.
- Latency:
  - SS_n low for 520 clks per frame, then high for GAP_CLKS, then low for 520 clks.
  - cnv_cmplt rises 1040+GAP_CLKS clks after the accept edge (1072 with default).
- Back-to-back:
  - strt_cnv in the cycle after cnv_cmplt rises is accepted.
  - cnv_cmplt drops and the new frame starts on that same edge.
- res holds its value until the next completion, including during a new conversion.

Decomposition:
- Package a2d_pkg:
  - state_t enum {IDLE, FRM1, GAP, FRM2}.
  - SCLK_LOAD=5'b10111, SAMPLE_PT=5'b10001, FRAME_END=5'b11110.
  - CMD_PAD=11'h000.
- One sub-module, spi_mstr16:
  - Single 16-bit frame engine.
  - Interface: wrt, cmd[15:0], rd_data[15:0], done, SS_n, SCLK, MOSI, MISO.
  - a2d_intf sequences two frames through it plus the GAP counter.

Test Plan:
- Basic conversion:
  - Stimulus: chnnl=3'b101, strt_cnv pulse; ADC model returns 12'hA5C in frame 2.
  - Required: MOSI frame 1 = 16'h2800; res=12'hA5C; cnv_cmplt rises exactly 1072 clks after the accept edge.
- SCLK timing:
  - Required: period 32 clks, 50% duty.
  - Required: first fall 9 clks after SS_n falls; 16 rises per frame; SS_n high 32 clks between frames; SCLK=1 whenever SS_n=1.
- Busy protection:
  - Stimulus: strt_cnv plus chnnl=3'b010 pulsed mid-FRM1 of a chnnl=3'b001 conversion.
  - Required: no restart; frame 2 still follows; completion at 1072; second command never appears.
- Back-to-back:
  - Stimulus: strt_cnv (chnnl=3'b111) on the cycle after cnv_cmplt rises.
  - Required: cnv_cmplt=0 the following cycle; new frame 1 word 16'h3800; previous res held until the new completion.
- Reset mid-conversion:
  - Stimulus: rst_n low during FRM2.
  - Required: immediately SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=0.
  - Required: after release, a full conversion of chnnl=0 returns the model value 12'hFFF.
- Channel sweep:
  - Stimulus: chnnl 0..7 with model data 12'h000, 12'h001, 12'h800, 12'hFFF, and others.
  - Required: command bits [13:11] match chnnl every time; res matches model data exactly.
